intc_nest_unit: RTL
===================

Name: intc_nest_unit

Overview:
- Parametrised, nesting-capable interrupt sequencer for the jacaranda-8 core family.
- Replaces the single-request, single-level return-address/flag save in the CPU with N prioritised channels and a return stack of depth STACK_D.
- Sits beside the CPU core: the core supplies its next PC and flag; this block redirects the PC on acceptance and restores PC/flag on return-from-interrupt.

Parameters:
DATA_W, 8, PC/data width
N_CH, 4, number of interrupt channels; channel 0 is the highest priority
STACK_D, 4, maximum nesting depth (return-stack entries)
VEC_SHIFT, 2, vector spacing: vector = vec_base + (ch << VEC_SHIFT)

Ports:
clock  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
irq_in  in  N_CH  request lines, synchronous to clock
int_en  in  N_CH  per-channel enable mask
gie  in  1  global interrupt enable
vec_base  in  DATA_W  vector table base address
pc_next  in  DATA_W  address the core would execute next (jump target or pc+1)
flag_in  in  1  current core flag
ret  in  1  core is executing return-from-interrupt this cycle
take  out  1  accept this cycle; core must load vec_out into PC
vec_out  out  DATA_W  vector of the accepted channel
restore  out  1  pop this cycle; core must load ret_addr and flag_out
ret_addr  out  DATA_W  top-of-stack return address
flag_out  out  1  top-of-stack saved flag
in_service  out  1  stack not empty
nest_level  out  clog2(STACK_D+1)  current stack occupancy
pending  out  N_CH  latched pending bits
err  out  2  sticky flags: [0] ret with empty stack, [1] request blocked by full stack

Behaviour:
- Reset (async, rst_n=0): pending=0, stack empty, nest_level=0, err=0, edge-history register=0. take=0, restore=0, in_service=0. ret_addr/flag_out read as 0 while the stack is empty.
- Edge capture: pending[i] is set on the clock after irq_in[i] goes 0->1 (compared against the previous-cycle sample). Level-high input does not re-set a cleared bit. Pending is independent of int_en: masked requests stay latched.
- Candidate: lowest index i with pending[i] & int_en[i].
- Preemption level:
  - While in_service=1, a candidate is eligible only if its index is strictly lower than the channel at top of stack.
  - While in_service=0, any candidate is eligible.
- take is combinational. take=1 when gie=1, an eligible candidate exists, ret=0, and nest_level<STACK_D.
- vec_out = (vec_base + (ch<<VEC_SHIFT)) mod 2^DATA_W, valid whenever take=1.
- At the take edge:
  - push {pc_next, flag_in, ch}
  - clear pending[ch]
  - nest_level+1
- Same-cycle edge and clear: if a new rising edge on irq_in[ch] arrives in the take cycle, pending[ch] stays set (set wins).
- Full stack: an eligible candidate with nest_level==STACK_D is not accepted and stays pending; err[1] sets.
- restore = ret & in_service (combinational). On that edge the stack pops and nest_level-1. ret_addr/flag_out present the top entry before the pop.
- ret with an empty stack is ignored and sets err[0].
- ret and an eligible candidate in the same cycle: the pop has priority and take=0. The candidate is re-evaluated the next cycle against the new top.
- err bits clear only on reset.
- Latency: request edge to take = 1 cycle minimum. take/restore are single-cycle and never both high.

Optional Feature:
- Macro: INTC_SW_TRIG_EN.
- When defined:
  - Adds input sw_set[N_CH]; sw_set[i]=1 sets pending[i] at the next edge, same priority and clearing rules as hardware edges.
  - Adds input sw_clr[N_CH]; sw_clr[i]=1 clears pending[i]; set beats clear if both are asserted.
- When undefined: neither port exists and pending is driven by irq_in edges only.

Test Plan:
- Reset mid-nest: two levels pushed, rst_n=0 asynchronously -> nest_level=0, pending=0, take=0 with no clock edge; err=0.
- Single request, defaults: vec_base=8'h40, gie=1, int_en=4'hF, irq_in[2] rises, pc_next=8'h13, flag_in=1 -> one cycle later take=1, vec_out=8'h48. Then ret=1 -> restore=1, ret_addr=8'h13, flag_out=1, nest_level back to 0.
- Simultaneous requests: irq_in[1] and irq_in[3] rise together -> ch1 taken first, vec_out=8'h44, pending=4'b1000. ch3 is not taken while ch1 is in service; after ret it is taken next (vec_out=8'h4C).
- Nesting and full stack:
  - STACK_D=2; ch3 taken, then ch1 taken -> nest_level=2.
  - ch0 rises -> take=0, err[1]=1, pending[0] stays 1.
  - ret -> ch0 taken on the following cycle.
- Collision and underflow:
  - ret with a ch0 pending at level 1 -> restore=1, take=0 that cycle, take=1 next cycle.
  - ret at nest_level=0 -> restore=0, err[0]=1.
- Masks and wrap: int_en[2]=0 with a ch2 edge -> pending[2]=1, no take; setting int_en[2]=1 -> take. vec_base=8'hFC with ch2 -> vec_out=8'h04 (wrap).

Source files
------------

// File: rtl/intc_nest_unit.sv
// rtl/intc_nest_unit.sv - nesting interrupt sequencer with prioritised channels and return stack
//
// Purpose:
//   Latches rising edges on N_CH request lines and picks the lowest-index
//   enabled pending channel. A channel is accepted only if it preempts the
//   channel on top of the return stack. On acceptance the core's next PC and
//   flag are pushed with the channel number, and the PC is redirected to the
//   channel vector. On return-from-interrupt the top entry is presented and
//   popped.
//
// Optional feature:
//   INTC_SW_TRIG_EN - adds sw_set/sw_clr software set/clear of pending bits.
//
// Ports:
//   clock      in   rising-edge system clock
//   rst_n      in   asynchronous active-low reset
//   irq_in     in   request lines (edge captured)
//   int_en     in   per-channel enable mask
//   gie        in   global interrupt enable
//   vec_base   in   vector table base
//   pc_next    in   address the core would execute next
//   flag_in    in   current core flag
//   ret        in   core executes return-from-interrupt
//   sw_set     in   software pending set   (INTC_SW_TRIG_EN only)
//   sw_clr     in   software pending clear (INTC_SW_TRIG_EN only)
//   take       out  accept this cycle, load vec_out into PC
//   vec_out    out  vector of the candidate channel
//   restore    out  pop this cycle, load ret_addr/flag_out
//   ret_addr   out  top-of-stack return address (0 when empty)
//   flag_out   out  top-of-stack saved flag (0 when empty)
//   in_service out  stack not empty
//   nest_level out  stack occupancy
//   pending    out  latched pending bits
//   err        out  sticky: [0] ret on empty stack, [1] request blocked by full stack

module intc_nest_unit #(
  parameter int DATA_W    = 8,
  parameter int N_CH      = 4,
  parameter int STACK_D   = 4,
  parameter int VEC_SHIFT = 2,
  localparam int LVL_W    = $clog2(STACK_D + 1),
  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   irq_in,
  input  logic [N_CH-1:0]   int_en,
  input  logic              gie,
  input  logic [DATA_W-1:0] vec_base,
  input  logic [DATA_W-1:0] pc_next,
  input  logic              flag_in,
  input  logic              ret,
`ifdef INTC_SW_TRIG_EN
  input  logic [N_CH-1:0]   sw_set,
  input  logic [N_CH-1:0]   sw_clr,
`endif
  output logic              take,
  output logic [DATA_W-1:0] vec_out,
  output logic              restore,
  output logic [DATA_W-1:0] ret_addr,
  output logic              flag_out,
  output logic              in_service,
  output logic [LVL_W-1:0]  nest_level,
  output logic [N_CH-1:0]   pending,
  output logic [1:0]        err
);

  logic [N_CH-1:0]   irq_prev_q;
  logic [N_CH-1:0]   pending_q, pending_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [1:0]        err_q, err_d;

  logic [DATA_W-1:0] stk_pc_q   [STACK_D];
  logic              stk_flag_q [STACK_D];
  logic [CH_W-1:0]   stk_ch_q   [STACK_D];

  logic              cand_valid;
  logic [CH_W-1:0]   cand_ch;
  logic [DATA_W-1:0] top_pc;
  logic              top_flag;
  logic [CH_W-1:0]   top_ch;
  logic              eligible;
  logic              can_push;
  logic              blocked_full;
  logic [N_CH-1:0]   set_vec;
  logic [N_CH-1:0]   clr_vec;

  // Lowest enabled pending index wins; scanning downward lets the last hit be the lowest.
  always_comb begin
    cand_valid = 1'b0;
    cand_ch    = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pending_q[i] && int_en[i]) begin
        cand_valid = 1'b1;
        cand_ch    = CH_W'(i);
      end
    end
  end

  // Top entry sits at index level_q-1; reads as zero while the stack is empty.
  always_comb begin
    top_pc   = '0;
    top_flag = 1'b0;
    top_ch   = '0;
    for (int i = 0; i < STACK_D; i++) begin
      if (level_q == LVL_W'(i + 1)) begin
        top_pc   = stk_pc_q[i];
        top_flag = stk_flag_q[i];
        top_ch   = stk_ch_q[i];
      end
    end
  end

  assign in_service = (level_q != '0);
  // Only a strictly higher-priority (lower-index) channel may preempt the one in service.
  assign eligible   = cand_valid && (!in_service || (cand_ch < top_ch));
  assign can_push   = (level_q < LVL_W'(STACK_D));
  // A return in the same cycle has priority: the candidate is re-judged against the new top.
  assign take         = gie && eligible && !ret && can_push;
  assign blocked_full = gie && eligible && !ret && !can_push;
  assign restore      = ret && in_service;

  assign vec_out    = vec_base + (DATA_W'(cand_ch) << VEC_SHIFT);
  assign ret_addr   = top_pc;
  assign flag_out   = top_flag;
  assign nest_level = level_q;
  assign pending    = pending_q;
  assign err        = err_q;

  // Set wins over clear so an edge arriving in the take cycle is not lost.
  always_comb begin
    set_vec = irq_in & ~irq_prev_q;
    for (int i = 0; i < N_CH; i++) begin
      clr_vec[i] = take && (cand_ch == CH_W'(i));
    end
`ifdef INTC_SW_TRIG_EN
    set_vec = set_vec | sw_set;
    clr_vec = clr_vec | sw_clr;
`endif
    pending_d = (pending_q & ~clr_vec) | set_vec;
  end

  always_comb begin
    level_d = level_q;
    if (take) begin
      level_d = level_q + LVL_W'(1);
    end else if (restore) begin
      level_d = level_q - LVL_W'(1);
    end
    err_d = err_q | {blocked_full, ret && !in_service};
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      irq_prev_q <= '0;
      pending_q  <= '0;
      level_q    <= '0;
      err_q      <= '0;
    end else begin
      irq_prev_q <= irq_in;
      pending_q  <= pending_d;
      level_q    <= level_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STACK_D; i++) begin
        stk_pc_q[i]   <= '0;
        stk_flag_q[i] <= 1'b0;
        stk_ch_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < STACK_D; i++) begin
        if (take && (level_q == LVL_W'(i))) begin
          stk_pc_q[i]   <= pc_next;
          stk_flag_q[i] <= flag_in;
          stk_ch_q[i]   <= cand_ch;
        end
      end
    end
  end

endmodule
